// File: rtl/two_comp_pipe_if.sv
// two_comp_pipe_if -- operand/result handshake bundle for two_comp_pipe.
//
// Signals:
//   in_valid, in_ready  : operand channel handshake
//   data_in [WIDTH]     : signed two's-complement operand
//   mode [2]            : 00 pass, 01 negate, 10 |x|, 11 -|x|
//   out_valid, out_ready: result channel handshake
//   data_out [WIDTH]    : result
//   ovf                 : result not representable in WIDTH bits
//
// Modports:
//   master : the producer/consumer side (testbench or surrounding logic)
//   slave  : the pipeline itself
interface two_comp_pipe_if #(
  parameter int WIDTH = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             ovf;

  modport master (
    output in_valid, data_in, mode, out_ready,
    input  in_ready, out_valid, data_out, ovf
  );

  modport slave (
    input  in_valid, data_in, mode, out_ready,
    output in_ready, out_valid, data_out, ovf
  );
endinterface

// File: rtl/two_comp_pipe.sv
// two_comp_pipe -- pipelined two's-complement unit (pass / negate / |x| / -|x|).
//
// The operand is conditionally inverted at the input and the "+1" of the
// negation is rippled through STAGES registered carry segments of SEG bits
// (the last segment takes the remaining bits). Latency is STAGES cycles.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : two_comp_pipe_if.slave (in_valid/in_ready/data_in/mode,
//           out_valid/out_ready/data_out/ovf)
//
// Parameters:
//   WIDTH : operand/result width (2..64)
//   SEG   : carry segment width (1..WIDTH)
//
// Optional feature macro: TWO_COMP_SAT_EN -- when defined, overflowing results
// (most-negative input with negate or |x|) saturate to the most-positive value;
// otherwise they wrap. ovf is asserted in both builds.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1. The producer holds valid and data stable until the transfer. Ready never
// depends combinationally on the same channel's valid. The whole pipe advances
// together when adv = ~out_valid | out_ready, and in_ready = adv, so a result
// held under backpressure keeps data_out/ovf/out_valid stable.
module two_comp_pipe #(
  parameter int WIDTH = 25,
  parameter int SEG   = 8
) (
  input logic            clk,
  input logic            rst_n,
  two_comp_pipe_if.slave bus
);
  localparam int STAGES = (WIDTH + SEG - 1) / SEG;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic adv;
  logic inv;
  logic [WIDTH-1:0] operand_x;
  logic ovf_in;

  // Per-stage state: segments below stage k are finished, the rest still hold
  // the (possibly inverted) operand waiting for their carry.
  logic             vld_q [STAGES];
  logic [WIDTH-1:0] dat_q [STAGES];
  logic             cry_q [STAGES];
  logic             ovf_q [STAGES];
`ifdef TWO_COMP_SAT_EN
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  logic             sat_q [STAGES];
`endif

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    inv = 1'b0;
    case (bus.mode)
      2'b01:   inv = 1'b1;
      2'b10:   inv = bus.data_in[WIDTH-1];
      2'b11:   inv = ~bus.data_in[WIDTH-1];
      default: inv = 1'b0;
    endcase
  end

  assign operand_x = inv ? ~bus.data_in : bus.data_in;

  // Only negating the most-negative value leaves the representable range;
  // -|x| of it is itself, so mode 11 never overflows.
  assign ovf_in = (bus.data_in == MIN_VAL) &&
                  ((bus.mode == 2'b01) || (bus.mode == 2'b10));

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int HI = ((k + 1) * SEG > WIDTH) ? WIDTH - 1 : (k + 1) * SEG - 1;
    localparam int SW = HI - LO + 1;

    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] nxt_data;
    logic             src_cin;
    logic             src_vld;
    logic             src_ovf;
    logic [SW:0]      seg_sum;
`ifdef TWO_COMP_SAT_EN
    logic             src_sat;
`endif

    if (k == 0) begin : g_first
      assign src_data = operand_x;
      assign src_cin  = inv;
      assign src_vld  = bus.in_valid;
      assign src_ovf  = ovf_in;
`ifdef TWO_COMP_SAT_EN
      assign src_sat  = ovf_in;
`endif
    end else begin : g_next
      assign src_data = dat_q[k-1];
      assign src_cin  = cry_q[k-1];
      assign src_vld  = vld_q[k-1];
      assign src_ovf  = ovf_q[k-1];
`ifdef TWO_COMP_SAT_EN
      assign src_sat  = sat_q[k-1];
`endif
    end

    assign seg_sum = {1'b0, src_data[HI:LO]} + {{SW{1'b0}}, src_cin};

    always_comb begin
      nxt_data        = src_data;
      nxt_data[HI:LO] = seg_sum[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
        cry_q[k] <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (adv) begin
        vld_q[k] <= src_vld;
        dat_q[k] <= nxt_data;
        // Carry out of the top segment is modulo-2^WIDTH overflow: dropped.
        cry_q[k] <= (k == STAGES - 1) ? 1'b0 : seg_sum[SW];
        ovf_q[k] <= src_ovf;
      end
    end

`ifdef TWO_COMP_SAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sat_q[k] <= 1'b0;
      end else if (adv) begin
        sat_q[k] <= src_sat;
      end
    end
`endif
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.ovf       = ovf_q[STAGES-1];
`ifdef TWO_COMP_SAT_EN
  assign bus.data_out  = sat_q[STAGES-1] ? MAX_VAL : dat_q[STAGES-1];
`else
  assign bus.data_out  = dat_q[STAGES-1];
`endif
endmodule

// File: tb/tb_two_comp_pipe.sv
// tb_two_comp_pipe -- self-checking bench for two_comp_pipe (WIDTH=25, SEG=8).
// Expected results come from a signed-arithmetic reference model; a negedge
// monitor keeps the scoreboard queue and the stall/hold rules.
module tb_two_comp_pipe;
  localparam int W      = 25;
  localparam int SEG    = 8;
  localparam int STAGES = 4;
  localparam logic [W-1:0] MIN_V  = 25'h1000000;
  localparam logic [W-1:0] MAX_V  = 25'h0FFFFFF;
  localparam logic [W-1:0] ONES_V = 25'h1FFFFFF;
  localparam longint HALF = longint'(1) << (W - 1);
`ifdef TWO_COMP_SAT_EN
  localparam logic [W-1:0] MIN_NEG_RES = MAX_V;
`else
  localparam logic [W-1:0] MIN_NEG_RES = MIN_V;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  two_comp_pipe_if #(.WIDTH(W)) bus ();

  two_comp_pipe #(.WIDTH(W), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];   // {ovf, data_out}

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [1:0] m);
    longint v;
    longint r;
    logic   o;
    logic [W-1:0] q;
    v = longint'($signed(d));
    case (m)
      2'b00:   r = v;
      2'b01:   r = -v;
      2'b10:   r = (v < 0) ? -v : v;
      default: r = (v < 0) ? v : -v;
    endcase
    o = (r > HALF - 1) || (r < -HALF);
    q = r[W-1:0];
`ifdef TWO_COMP_SAT_EN
    if (o) q = MAX_V;
`endif
    return {o, q};
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic       hold_prev;
    logic [W:0] hold_val;
    logic [W:0] e;
    hold_prev = 1'b0;
    hold_val  = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (hold_prev) begin
          checks++;
          if (bus.out_valid !== 1'b1 || {bus.ovf, bus.data_out} !== hold_val) begin
            errors++;
            $display("FAIL hold_stable got v=%b %h want v=1 %h", bus.out_valid,
                     {bus.ovf, bus.data_out}, hold_val);
          end
        end
        checks++;
        if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
          errors++;
          $display("FAIL stall_rule in_ready=%b out_valid=%b out_ready=%b",
                   bus.in_ready, bus.out_valid, bus.out_ready);
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output got %h want none", {bus.ovf, bus.data_out});
          end else begin
            e = exp_q.pop_front();
            if ({bus.ovf, bus.data_out} !== e) begin
              errors++;
              $display("FAIL scoreboard got ovf=%b data=%h want ovf=%b data=%h",
                       bus.ovf, bus.data_out, e[W], e[W-1:0]);
            end
          end
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus.data_in, bus.mode));
        hold_prev = bus.out_valid && !bus.out_ready;
        hold_val  = {bus.ovf, bus.data_out};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    bit found;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = 25'h0000007;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.ovf !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b ovf=%b d=%h want 0 0 0",
               bus.out_valid, bus.ovf, bus.data_out);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      n++;
      if (n == 1) #1 bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != STAGES) begin
      errors++; $display("FAIL first_after_reset_latency got %0d want %0d", n, STAGES);
    end
    checks++;
    if (bus.data_out !== 25'h0000007) begin
      errors++; $display("FAIL first_after_reset_data got %h want 0000007", bus.data_out);
    end
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] d,
                               input logic [1:0] m, input logic [W-1:0] ed,
                               input logic eo);
    int n;
    bit found;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = d;
    bus.mode      = m;
    n = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk);
      n++;
      if (n == 1) #1 bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid === 1'b1) found = 1;
    end
    checks++;
    if (!found || n != STAGES) begin
      errors++; $display("FAIL %s latency got %0d want %0d", name, n, STAGES);
    end
    checks++;
    if (bus.data_out !== ed || bus.ovf !== eo) begin
      errors++;
      $display("FAIL %s result got data=%h ovf=%b want data=%h ovf=%b",
               name, bus.data_out, bus.ovf, ed, eo);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ops [10];
    logic [1:0]   mds [10];
    int idx;
    int outs;
    int stall_cnt;
    bit acc;
    for (int i = 0; i < 10; i++) begin
      ops[i] = W'($urandom);
      mds[i] = 2'($urandom_range(0, 3));
    end
    idx = 0; outs = 0; stall_cnt = 0; acc = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (idx < 10) begin
        bus.in_valid = 1'b1;
        bus.data_in  = ops[idx];
        bus.mode     = mds[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = !(c >= 6 && c <= 9);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      if (bus.in_ready === 1'b0) stall_cnt++;
      if (bus.out_valid && bus.out_ready) outs++;
      if (idx >= 10 && !acc && exp_q.size() == 0 && c > 20) break;
    end
    checks++;
    if (outs != 10) begin
      errors++; $display("FAIL b2b_output_count got %0d want 10", outs);
    end
    checks++;
    if (stall_cnt != 4) begin
      errors++; $display("FAIL b2b_stall_cycles got %0d want 4", stall_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int stale;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.data_in  = W'($urandom);
      bus.mode     = 2'($urandom_range(0, 3));
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.data_out !== '0) begin
      errors++;
      $display("FAIL midflight_reset_clear got v=%b d=%h want 0 0", bus.out_valid, bus.data_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midflight_stale got %0d want 0", stale);
    end
    test_directed("post_reset", 25'h0000010, 2'b01, 25'h1FFFFF0, 1'b0);
  endtask

  task automatic test_random();
    int xfers;
    int cyc;
    bit acc;
    xfers = 0; cyc = 0; acc = 0;
    bus.in_valid = 1'b0;
    while (xfers < 10000 && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (acc) xfers++;
      if (!bus.in_valid || acc) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0:       bus.data_in = MIN_V;
          1:       bus.data_in = '0;
          2:       bus.data_in = ONES_V;
          3:       bus.data_in = MAX_V;
          default: bus.data_in = W'($urandom);
        endcase
        bus.mode = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
    end
    checks++;
    if (xfers < 10000) begin
      errors++; $display("FAIL random_transfers got %0d want 10000", xfers);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL random_drain got %0d want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed("neg_5",       25'h0000005, 2'b01, 25'h1FFFFFB, 1'b0);
    test_directed("abs_min",     MIN_V,       2'b10, MIN_NEG_RES, 1'b1);
    test_directed("neg_min",     MIN_V,       2'b01, MIN_NEG_RES, 1'b1);
    test_directed("neg_ff",      25'h00000FF, 2'b01, 25'h1FFFF01, 1'b0);
    test_directed("neg_zero",    25'h0000000, 2'b01, 25'h0000000, 1'b0);
    test_directed("abs_m1",      ONES_V,      2'b10, 25'h0000001, 1'b0);
    test_directed("nabs_min",    MIN_V,       2'b11, MIN_V,       1'b0);
    test_directed("nabs_pos",    25'h0000010, 2'b11, 25'h1FFFFF0, 1'b0);
    test_directed("pass",        25'h1ABCDEF, 2'b00, 25'h1ABCDEF, 1'b0);
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
